serializador: RTL and testbench

- Upstream neighbour of the deserializer stage.
- Accepts parallel bytes from the producer into a small input FIFO.
- Transmits each byte LSB-first on a 1-bit serial line (data_out) framed by write_out.
- Holds off the next byte until the downstream stage has raised and then dropped its busy flag (status_in).

---
 rtl/serializador_pkg.sv | 18 +
 rtl/serializador_if.sv | 28 ++
 rtl/serializador_fifo_sincrona.sv | 62 ++++++
 rtl/serializador.sv | 127 ++++++++++++
 tb/tb_serializador.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serializador_pkg.sv
// Shared types for the serializer: FSM states and byte sizing.
// Imported by the interface, the FIFO user and the top.
package serializador_pkg;

   localparam int BYTE_WIDTH  = 8;
   localparam int BIT_COUNT_W = 3;

   typedef logic [BYTE_WIDTH-1:0] byte_t;

   typedef enum logic [2:0] {
      OCIOSO,
      INICIO,
      ENVIA,
      AGUARDA_OCUPADO,
      AGUARDA_LIVRE
   } state_t;

endpackage

// File: rtl/serializador_if.sv
// Producer/serial-line bundle of the serializer.
// master = environment side, slave = serializer side.
interface serializador_if;
   import serializador_pkg::*;

   byte_t data_in;
   logic  write_in;
   logic  status_in;
   logic  data_out;
   logic  write_out;

   modport master (
      output data_in,
      output write_in,
      output status_in,
      input  data_out,
      input  write_out
   );

   modport slave (
      input  data_in,
      input  write_in,
      input  status_in,
      output data_out,
      output write_out
   );

endinterface

// File: rtl/serializador_fifo_sincrona.sv
// Synchronous FIFO with registered full/empty flags.
// Full/empty refer to the occupancy before the current edge.
module fifo_sincrona #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock_100KHz,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_nx;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_nx = count;
      unique case ({do_push, do_pop})
         2'b10:   count_nx = count + 1'b1;
         2'b01:   count_nx = count - 1'b1;
         default: count_nx = count;
      endcase
   end

   // power-of-two depth: pointers wrap by natural overflow
   always_ff @(posedge clock_100KHz or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nx;
         full  <= (count_nx == DEPTH_C);
         empty <= (count_nx == '0);
      end
   end

   always_ff @(posedge clock_100KHz) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/serializador.sv
// Byte-to-serial transmitter, LSB-first with a start cycle, ack-paced.
// Optional downstream timeout: define SERIALIZADOR_TIMEOUT_EN.
module serializador
   import serializador_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic           clock_100KHz,
   input  logic           reset,
   serializador_if.slave  bus,
   output logic           fifo_full,
   output logic           fifo_empty,
   output logic           overflow_out,
   output logic           error_out
);

   state_t                 state;
   byte_t                  shift;
   byte_t                  head;
   logic [BIT_COUNT_W-1:0] bit_cnt;
   logic                   data_q;
   logic                   write_q;
   logic                   pop;

   assign pop = (state == OCIOSO) && !fifo_empty && !bus.status_in;

   assign bus.data_out  = data_q;
   assign bus.write_out = write_q;

   fifo_sincrona #(
      .WIDTH (BYTE_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock_100KHz (clock_100KHz),
      .reset        (reset),
      .push         (bus.write_in),
      .pop          (pop),
      .din          (bus.data_in),
      .dout         (head),
      .full         (fifo_full),
      .empty        (fifo_empty)
   );

   always_ff @(posedge clock_100KHz or negedge reset) begin
      if (!reset) begin
         overflow_out <= 1'b0;
      end else if (bus.write_in && fifo_full) begin
         overflow_out <= 1'b1;
      end
   end

`ifdef SERIALIZADOR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] wait_cnt;
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYCLES > 0);
   assign error_out  = 1'b0;
`endif

   always_ff @(posedge clock_100KHz or negedge reset) begin
      if (!reset) begin
         state   <= OCIOSO;
         shift   <= '0;
         bit_cnt <= '0;
         data_q  <= 1'b0;
         write_q <= 1'b0;
`ifdef SERIALIZADOR_TIMEOUT_EN
         wait_cnt  <= '0;
         error_out <= 1'b0;
`endif
      end else begin
         unique case (state)
            OCIOSO: begin
               write_q <= 1'b0;
               data_q  <= 1'b0;
               if (pop) begin
                  shift   <= head;
                  bit_cnt <= '0;
                  write_q <= 1'b1;
                  state   <= INICIO;
               end
            end
            // start cycle done; next cycles carry bits 0..7
            INICIO: begin
               data_q <= shift[0];
               shift  <= shift >> 1;
               state  <= ENVIA;
            end
            ENVIA: begin
               if (bit_cnt == {BIT_COUNT_W{1'b1}}) begin
                  write_q <= 1'b0;
                  data_q  <= 1'b0;
                  state   <= AGUARDA_OCUPADO;
`ifdef SERIALIZADOR_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end else begin
                  data_q  <= shift[0];
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            AGUARDA_OCUPADO: begin
               if (bus.status_in) begin
                  state <= AGUARDA_LIVRE;
               end
`ifdef SERIALIZADOR_TIMEOUT_EN
               else if (wait_cnt == TMO_LAST) begin
                  error_out <= 1'b1;
                  state     <= OCIOSO;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            AGUARDA_LIVRE: begin
               if (!bus.status_in) state <= OCIOSO;
            end
            default: state <= OCIOSO;
         endcase
      end
   end

endmodule

// File: tb/tb_serializador.sv
// Directed bench for serializador with a frame-slot model and receiver.
// Build with SERIALIZADOR_TIMEOUT_EN defined to cover the timeout path.
module tb_serializador;
   import serializador_pkg::*;

   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic clock_100KHz = 1'b0;
   logic reset = 1'b0;
   logic fifo_full, fifo_empty, overflow_out, error_out;

   serializador_if bus();

   serializador #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock_100KHz (clock_100KHz),
      .reset        (reset),
      .bus          (bus),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .overflow_out (overflow_out),
      .error_out    (error_out)
   );

   always #5 clock_100KHz = ~clock_100KHz;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // model: queue of bytes, transmitter phase (-1 idle, 0..8 frame
   // slots, 9 awaiting busy, 10 awaiting free)
   logic [7:0] mq[$];
   logic [7:0] sent[$];
   logic [7:0] cur = '0;
   int  ph = -1;
   int  tw = 0;
   bit  pop_now, full_now;
   logic e_wo = 0, e_do = 0, e_full = 0, e_empty = 1;
   logic e_ovf = 0, e_err = 0;

   always @(posedge clock_100KHz or negedge reset) begin
      if (!reset) begin
         mq.delete();
         sent.delete();
         ph = -1;
         e_wo = 0; e_do = 0; e_full = 0; e_empty = 1;
         e_ovf = 0; e_err = 0;
      end else begin
         full_now = (mq.size() == DEPTH);
         pop_now  = (ph == -1) && (mq.size() > 0) && !bus.status_in;
         if (bus.write_in && full_now) e_ovf = 1;
         if (ph == -1) begin
            if (pop_now) begin
               cur = mq.pop_front();
               sent.push_back(cur);
               ph = 0;
            end
         end else if (ph <= 7) begin
            ph++;
         end else if (ph == 8) begin
            ph = 9;
            tw = 0;
         end else if (ph == 9) begin
            if (bus.status_in) ph = 10;
`ifdef SERIALIZADOR_TIMEOUT_EN
            else begin
               tw++;
               if (tw == TMO) begin
                  e_err = 1;
                  ph = -1;
               end
            end
`endif
         end else if (ph == 10) begin
            if (!bus.status_in) ph = -1;
         end
         if (bus.write_in && !full_now) mq.push_back(bus.data_in);
         e_wo    = (ph >= 0) && (ph <= 8);
         e_do    = (ph >= 1 && ph <= 8) ? cur[ph-1] : 1'b0;
         e_empty = (mq.size() == 0);
         e_full  = (mq.size() == DEPTH);
      end
   end

   always @(negedge clock_100KHz) begin
      chk("write_out", bus.write_out, e_wo);
      chk("data_out", bus.data_out, e_do);
      chk("fifo_full", fifo_full, e_full);
      chk("fifo_empty", fifo_empty, e_empty);
      chk("overflow_out", overflow_out, e_ovf);
      chk("error_out", error_out, e_err);
   end

   // receiver: collects bits 0..7 after the start slot
   logic [7:0] rx_b = '0;
   int rx_n = 0;
   logic [7:0] rx_q[$];

   always @(negedge clock_100KHz) begin
      if (!reset) begin
         rx_n = 0;
      end else if (bus.write_out) begin
         if (rx_n >= 1 && rx_n <= 8) rx_b[rx_n-1] = bus.data_out;
         rx_n++;
      end else if (rx_n > 0) begin
         rx_q.push_back(rx_b);
         if (sent.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_extra actual=%0h required=none", rx_b);
         end else begin
            chk("rx_byte", rx_b, sent.pop_front());
         end
         rx_n = 0;
      end
   end

   // downstream responder: busy pulse 3 cycles after each frame
   bit   auto_ack = 0;
   int   ack_cnt = 0;
   logic wo_prev = 0;

   always @(negedge clock_100KHz) begin
      if (auto_ack) begin
         if (wo_prev && !bus.write_out) begin
            ack_cnt = 1;
         end else if (ack_cnt > 0) begin
            ack_cnt++;
            if (ack_cnt == 3) bus.status_in = 1'b1;
            else if (ack_cnt == 5) begin
               bus.status_in = 1'b0;
               ack_cnt = 0;
            end
         end
      end
      wo_prev = bus.write_out;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock_100KHz);
   endtask

   task automatic push_one(input logic [7:0] b);
      @(negedge clock_100KHz);
      bus.data_in  = b;
      bus.write_in = 1'b1;
   endtask

   task automatic push_end();
      @(negedge clock_100KHz);
      bus.write_in = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget);
      int c = 0;
      while (rx_q.size() < n && c < budget) begin
         @(negedge clock_100KHz);
         c++;
      end
      chk("frames_received", rx_q.size(), n);
   endtask

   task automatic wait_wo(input logic lvl, input int budget);
      int c = 0;
      while (bus.write_out !== lvl && c < budget) begin
         @(negedge clock_100KHz);
         c++;
      end
      chk("write_out_wait", bus.write_out, lvl);
   endtask

   logic seq_a5 [9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1};
   int n;

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      bus.data_in   = '0;
      bus.write_in  = 1'b0;
      bus.status_in = 1'b0;
      auto_ack = 1;
      tick(2);
      chk("rst_write_out", bus.write_out, 0);
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_full", fifo_full, 0);
      chk("rst_ovf", overflow_out, 0);
      chk("rst_err", error_out, 0);
      @(negedge clock_100KHz);
      reset = 1'b1;

      // single byte, latency and bit order
      push_one(8'hA5);
      push_end();
      chk("lat_push_edge", bus.write_out, 0);
      for (int i = 0; i < 9; i++) begin
         @(negedge clock_100KHz);
         chk("a5_wo", bus.write_out, 1);
         chk("a5_bit", bus.data_out, seq_a5[i]);
      end
      @(negedge clock_100KHz);
      chk("a5_end", bus.write_out, 0);
      wait_rx(1, 20);
      chk("a5_rx", rx_q[0], 8'hA5);

      // back-to-back bytes paced by busy pulses
      tick(10);
      push_one(8'h3C);
      push_one(8'hC3);
      push_one(8'hFF);
      push_one(8'h00);
      push_end();
      wait_rx(5, 200);
      chk("b2b_0", rx_q[1], 8'h3C);
      chk("b2b_1", rx_q[2], 8'hC3);
      chk("b2b_2", rx_q[3], 8'hFF);
      chk("b2b_3", rx_q[4], 8'h00);

      // blocked by busy: fill, overflow, then drain exactly 4
      tick(10);
      auto_ack = 0;
      bus.status_in = 1'b1;
      push_one(8'h11);
      push_one(8'h22);
      push_one(8'h33);
      push_one(8'h44);
      push_one(8'h55);
      chk("full_after_4", fifo_full, 1);
      chk("ovf_before_5", overflow_out, 0);
      push_end();
      chk("ovf_after_5", overflow_out, 1);
      chk("held_no_tx", rx_q.size(), 5);
      tick(3);
      bus.status_in = 1'b0;
      auto_ack = 1;
      wait_rx(9, 200);
      tick(40);
      chk("drain_count", rx_q.size(), 9);
      chk("drain_empty", fifo_empty, 1);
      chk("drain_0", rx_q[5], 8'h11);
      chk("drain_3", rx_q[8], 8'h44);

      // reset in the middle of bit 4
      tick(10);
      push_one(8'h66);
      push_one(8'h77);
      push_end();
      wait_wo(1, 20);
      tick(5);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_wo", bus.write_out, 0);
      chk("mid_rst_empty", fifo_empty, 1);
      chk("mid_rst_ovf", overflow_out, 0);
      chk("mid_rst_full", fifo_full, 0);
      tick(2);
      reset = 1'b1;
      tick(30);
      chk("no_tx_after_rst", rx_q.size(), 9);

      // push and pop on the same edge with two queued, pointers wrap
      tick(2);
      auto_ack = 0;
      bus.status_in = 1'b1;
      push_one(8'hA1);
      push_one(8'hB2);
      push_one(8'hC3);
      bus.status_in = 1'b0;
      @(negedge clock_100KHz);
      bus.data_in = 8'hD4;
      bus.status_in = 1'b1;
      chk("pp_empty", fifo_empty, 0);
      chk("pp_full", fifo_full, 0);
      push_one(8'hE5);
      push_end();
      chk("pp_full4", fifo_full, 1);
      chk("pp_no_ovf", overflow_out, 0);
      tick(16);
      bus.status_in = 1'b0;
      auto_ack = 1;
      wait_rx(14, 300);
      chk("pp_0", rx_q[9], 8'hA1);
      chk("pp_1", rx_q[10], 8'hB2);
      chk("pp_2", rx_q[11], 8'hC3);
      chk("pp_3", rx_q[12], 8'hD4);
      chk("pp_4", rx_q[13], 8'hE5);

      // downstream never answers
      tick(10);
      auto_ack = 0;
      push_one(8'h5A);
      push_one(8'h6B);
      push_end();
      wait_wo(1, 20);
      wait_wo(0, 20);
`ifdef SERIALIZADOR_TIMEOUT_EN
      n = 0;
      while (!error_out && n < 40) begin
         @(negedge clock_100KHz);
         n++;
      end
      chk("tmo_latency", n, TMO);
      chk("tmo_err", error_out, 1);
      auto_ack = 1;
      wait_rx(16, 100);
      chk("tmo_lost", rx_q[14], 8'h5A);
      chk("tmo_next", rx_q[15], 8'h6B);
`else
      tick(40);
      chk("stuck_err", error_out, 0);
      chk("stuck_count", rx_q.size(), 15);
      chk("stuck_empty", fifo_empty, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
